// File: rtl/mv_issue_sequencer.sv
`default_nettype none
// ============================================================================
// Module : mv_issue_sequencer
// Issues motion-vector candidates in raster order and hands them to a
// selector in batches, waiting for each batch result.
// Rev    : 1.0
// ============================================================================
module mv_issue_sequencer #(
  parameter int BATCH   = 3,
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  range,
  input  logic        sad_ready,
  input  logic        done_in,
  input  logic [13:0] MVSelected,
  output logic        WE,
  output logic [13:0] MVout,
  output logic        MVwait,
  output logic        busy,
  output logic        batch_valid,
  output logic [13:0] batch_mv,
  output logic        scan_done,
  output logic        timeout_err
);

  localparam int WCW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [4:0]       r_q, r_d;
  logic [6:0]       x_q, x_d, y_q, y_d;
  logic [11:0]      cnt_q, cnt_d;
  logic [1:0]       bcnt_q, bcnt_d;
  logic [WCW-1:0]   wcnt_q, wcnt_d;
  logic             we_q, we_d;
  logic [13:0]      mvout_q, mvout_d;
  logic             mvwait_q, mvwait_d;
  logic             busy_q, busy_d;
  logic             batch_valid_q, batch_valid_d;
  logic [13:0]      batch_mv_q, batch_mv_d;
  logic             scan_done_q, scan_done_d;
  logic             terr_q, terr_d;

  logic [6:0]       r_ext;
  logic [11:0]      side;
  logic [11:0]      total;
  logic             last_cand;
  logic             batch_full;
  logic             all_issued;

  // Candidate count is (2R+1)^2; the issue counter compares against it.
  assign r_ext      = {2'b00, r_q};
  assign side       = {6'd0, r_q, 1'b1};
  assign total      = side * side;
  assign last_cand  = (cnt_q == total - 12'd1);
  assign all_issued = (cnt_q == total);
  assign batch_full = (bcnt_q == 2'(BATCH - 1));

  always_comb begin
    state_d       = state_q;
    r_d           = r_q;
    x_d           = x_q;
    y_d           = y_q;
    cnt_d         = cnt_q;
    bcnt_d        = bcnt_q;
    wcnt_d        = wcnt_q;
    we_d          = 1'b0;
    mvout_d       = mvout_q;
    mvwait_d      = 1'b0;
    batch_valid_d = 1'b0;
    batch_mv_d    = batch_mv_q;
    terr_d        = terr_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ISSUE;
          r_d     = range;
          x_d     = -{2'b00, range};
          y_d     = -{2'b00, range};
          cnt_d   = '0;
          bcnt_d  = '0;
          terr_d  = 1'b0;
        end
      end
      ISSUE: begin
        if (sad_ready) begin
          we_d     = 1'b1;
          mvout_d  = {x_q, y_q};
          mvwait_d = last_cand || batch_full;
          cnt_d    = cnt_q + 12'd1;
          bcnt_d   = batch_full ? 2'd0 : bcnt_q + 2'd1;
          if (x_q == r_ext) begin
            x_d = -r_ext;
            y_d = y_q + 7'd1;
          end else begin
            x_d = x_q + 7'd1;
          end
          if (last_cand || batch_full) begin
            state_d = WAIT;
            wcnt_d  = '0;
          end
        end
      end
      WAIT: begin
        // A done_in arriving on the final allowed cycle still counts.
        if (done_in) begin
          batch_valid_d = 1'b1;
          batch_mv_d    = MVSelected;
          state_d       = all_issued ? DONE : ISSUE;
        end else if (wcnt_q == WCW'(TIMEOUT - 1)) begin
          terr_d  = 1'b1;
          state_d = all_issued ? DONE : ISSUE;
        end else begin
          wcnt_d = wcnt_q + WCW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d      = (state_d != IDLE);
    scan_done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      r_q           <= '0;
      x_q           <= '0;
      y_q           <= '0;
      cnt_q         <= '0;
      bcnt_q        <= '0;
      wcnt_q        <= '0;
      we_q          <= 1'b0;
      mvout_q       <= '0;
      mvwait_q      <= 1'b0;
      busy_q        <= 1'b0;
      batch_valid_q <= 1'b0;
      batch_mv_q    <= '0;
      scan_done_q   <= 1'b0;
      terr_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      r_q           <= r_d;
      x_q           <= x_d;
      y_q           <= y_d;
      cnt_q         <= cnt_d;
      bcnt_q        <= bcnt_d;
      wcnt_q        <= wcnt_d;
      we_q          <= we_d;
      mvout_q       <= mvout_d;
      mvwait_q      <= mvwait_d;
      busy_q        <= busy_d;
      batch_valid_q <= batch_valid_d;
      batch_mv_q    <= batch_mv_d;
      scan_done_q   <= scan_done_d;
      terr_q        <= terr_d;
    end
  end

  assign WE          = we_q;
  assign MVout       = mvout_q;
  assign MVwait      = mvwait_q;
  assign busy        = busy_q;
  assign batch_valid = batch_valid_q;
  assign batch_mv    = batch_mv_q;
  assign scan_done   = scan_done_q;
  assign timeout_err = terr_q;

endmodule
`default_nettype wire

// File: tb/tb_mv_issue_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_mv_issue_sequencer
// Randomized bench for mv_issue_sequencer against a transaction-level model.
// Rev    : 1.0
// ============================================================================
module tb_mv_issue_sequencer;

  localparam int BATCH   = 3;
  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  range;
  logic        sad_ready;
  logic        done_in;
  logic [13:0] MVSelected;
  logic        WE;
  logic [13:0] MVout;
  logic        MVwait;
  logic        busy;
  logic        batch_valid;
  logic [13:0] batch_mv;
  logic        scan_done;
  logic        timeout_err;

  mv_issue_sequencer #(.BATCH(BATCH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .start(start), .range(range),
    .sad_ready(sad_ready), .done_in(done_in), .MVSelected(MVSelected),
    .WE(WE), .MVout(MVout), .MVwait(MVwait), .busy(busy),
    .batch_valid(batch_valid), .batch_mv(batch_mv),
    .scan_done(scan_done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: expected candidate list plus scan/batch bookkeeping.
  logic [13:0] q[$];
  bit          m_active, m_waiting, m_bv, m_sd, m_terr, prev_ready;
  logic [13:0] m_bmv;
  int          m_issued, m_wcount;
  int          we_cnt, mvwait_cnt, bv_cnt, sd_cnt;
  logic [13:0] first_mv, last_bmv;

  function automatic void build(input int r);
    q.delete();
    for (int yy = -r; yy <= r; yy++)
      for (int xx = -r; xx <= r; xx++)
        q.push_back({7'(xx), 7'(yy)});
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      check("reset_ctl", {26'd0, WE, MVwait, busy, batch_valid, scan_done, timeout_err}, 32'd0);
      check("reset_mvout", {18'd0, MVout}, 32'd0);
      check("reset_batch_mv", {18'd0, batch_mv}, 32'd0);
      q.delete();
      m_active = 0; m_waiting = 0; m_bv = 0; m_sd = 0; m_terr = 0;
      prev_ready = 0; m_issued = 0; m_wcount = 0;
    end else begin : cmp
      bit resolved, n_bv, n_sd, n_active, exp_wait;
      check("busy", {31'd0, busy}, {31'd0, m_active});
      check("batch_valid", {31'd0, batch_valid}, {31'd0, m_bv});
      if (m_bv) check("batch_mv", {18'd0, batch_mv}, {18'd0, m_bmv});
      check("scan_done", {31'd0, scan_done}, {31'd0, m_sd});
      check("timeout_err", {31'd0, timeout_err}, {31'd0, m_terr});
      if (batch_valid) begin bv_cnt++; last_bmv = batch_mv; end
      if (scan_done) sd_cnt++;
      if (WE) begin
        we_cnt++;
        if (MVwait) mvwait_cnt++;
        check("we_legal", {29'd0, m_active, m_waiting, prev_ready}, 32'd5);
        if (q.size() == 0) begin
          checks++; failures++;
          $display("FAIL we_extra: got WE with MVout 0x%0h expected no candidate", MVout);
        end else begin
          exp_wait = ((m_issued + 1) % BATCH == 0) || (q.size() == 1);
          check("MVout", {18'd0, MVout}, {18'd0, q[0]});
          check("MVwait", {31'd0, MVwait}, {31'd0, exp_wait});
          if (m_issued == 0) first_mv = MVout;
          void'(q.pop_front());
          m_issued++;
          if (exp_wait) begin m_waiting = 1; m_wcount = 0; end
        end
      end else begin
        check("MVwait_without_WE", {31'd0, MVwait}, 32'd0);
      end
      resolved = 0; n_bv = 0;
      if (m_waiting) begin
        if (done_in) begin
          n_bv = 1; m_bmv = MVSelected; m_waiting = 0; resolved = 1;
        end else begin
          m_wcount++;
          if (m_wcount == TIMEOUT) begin m_terr = 1; m_waiting = 0; resolved = 1; end
        end
      end
      n_sd     = resolved && (q.size() == 0);
      n_active = m_sd ? 1'b0 : m_active;
      if (!m_active && start) begin
        n_active = 1; build(int'(range)); m_terr = 0; m_issued = 0;
      end
      m_active = n_active; m_bv = n_bv; m_sd = n_sd; prev_ready = sad_ready;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // rmode: 0 always ready, 1 toggle, 2 random. dmode: 0 never, 1 always, 2/3 random.
  task automatic run_scan(input int r, input int rmode, input int dmode, input bit noise);
    int sd0, budget, n;
    sd0    = sd_cnt;
    start  = 1'b1;
    range  = 5'(r);
    tick();
    start  = 1'b0;
    budget = (2 * r + 1) * (2 * r + 1) * 25 + 200;
    n      = 0;
    while (sd_cnt == sd0 && n < budget) begin
      case (rmode)
        0:       sad_ready = 1'b1;
        1:       sad_ready = ~sad_ready;
        default: sad_ready = 1'($urandom_range(0, 1));
      endcase
      case (dmode)
        0:       done_in = 1'b0;
        1:       done_in = 1'b1;
        2:       done_in = ($urandom_range(0, 3) == 0);
        default: done_in = ($urandom_range(0, 19) == 0);
      endcase
      MVSelected = (dmode == 1) ? 14'h0000 : 14'($urandom);
      if (noise) begin
        start = ($urandom_range(0, 15) == 0);
        range = 5'($urandom);
      end
      tick();
      n++;
    end
    start   = 1'b0;
    done_in = 1'b0;
    check("scan_completes", sd_cnt - sd0, 32'd1);
  endtask

  int we0, mw0, bv0, sd0;
  task automatic snap();
    we0 = we_cnt; mw0 = mvwait_cnt; bv0 = bv_cnt; sd0 = sd_cnt;
  endtask

  initial begin
    int k;
    reset = 1'b1; start = 1'b0; range = '0; sad_ready = 1'b0; done_in = 1'b0; MVSelected = '0;
    we_cnt = 0; mvwait_cnt = 0; bv_cnt = 0; sd_cnt = 0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // R=0: a single centre candidate.
    snap();
    run_scan(0, 0, 1, 1'b0);
    check("r0_we", we_cnt - we0, 32'd1);
    check("r0_mvwait", mvwait_cnt - mw0, 32'd1);
    check("r0_first_mv", {18'd0, first_mv}, 32'h0000);
    check("r0_batch_valid", bv_cnt - bv0, 32'd1);
    check("r0_batch_mv", {18'd0, last_bmv}, 32'h0000);

    // R=1: three full batches.
    snap();
    run_scan(1, 0, 1, 1'b0);
    check("r1_we", we_cnt - we0, 32'd9);
    check("r1_mvwait", mvwait_cnt - mw0, 32'd3);
    check("r1_first_mv", {18'd0, first_mv}, 32'h3FFF);
    check("r1_batch_valid", bv_cnt - bv0, 32'd3);

    // No selector response: every batch times out.
    snap();
    run_scan(1, 0, 0, 1'b0);
    check("to_we", we_cnt - we0, 32'd9);
    check("to_batch_valid", bv_cnt - bv0, 32'd0);
    check("to_timeout_err", {31'd0, timeout_err}, 32'd1);
    run_scan(1, 0, 1, 1'b0);
    check("to_cleared", {31'd0, timeout_err}, 32'd0);

    // R=2 with alternating ready.
    snap();
    run_scan(2, 1, 2, 1'b0);
    check("r2_toggle_we", we_cnt - we0, 32'd25);

    // R=2 with spurious start pulses mid-scan.
    snap();
    run_scan(2, 2, 2, 1'b1);
    check("r2_noise_we", we_cnt - we0, 32'd25);

    // Reset while waiting on the selector.
    start = 1'b1; range = 5'd2; tick();
    start = 1'b0; sad_ready = 1'b1; done_in = 1'b0;
    k = 0;
    while (!m_waiting && k < 50) begin tick(); k++; end
    check("reached_wait", {31'd0, m_waiting}, 32'd1);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    snap();
    repeat (20) tick();
    check("no_scan_done_after_reset", sd_cnt - sd0, 32'd0);
    check("no_bv_after_reset", bv_cnt - bv0, 32'd0);
    check("idle_after_reset", {31'd0, busy}, 32'd0);

    // Fresh scan after reset, then randomized scans.
    run_scan(1, 0, 1, 1'b0);
    for (int i = 0; i < 10; i++)
      run_scan($urandom_range(0, 6), $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom_range(0, 1)));

    snap();
    run_scan(31, 0, 1, 1'b0);
    check("r31_we", we_cnt - we0, 32'd3969);
    check("r31_mvwait", mvwait_cnt - mw0, 32'd1323);

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
